// File: rtl/dmem_pkg.sv
// dmem_pkg: shared sizing defaults, word-index helper and write-buffer entry type for dmem_wbuf
package dmem_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = $clog2(DEPTH);

    // Word index of a CPU byte address; callers truncate to their RAM address width.
    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf_fifo.sv
// dmem_wbuf_fifo: in-order store buffer with head/tail pointers and a youngest-match search
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset (discards all entries)
//   i_push/_addr/_data        enqueue one {word index, data} at the tail
//   i_pop                     retire the head entry
//   o_full, o_empty           occupancy flags from the count at the start of the cycle
//   o_head_addr/_data         oldest entry, presented for draining
//   i_srch_addr               word index to look up among valid entries
//   o_hit, o_hit_data         match flag and data of the youngest matching entry
module dmem_wbuf_fifo #(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W,
    parameter int DEPTH  = dmem_pkg::DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    input  logic [ADDR_W-1:0] i_srch_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_hit_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;
    logic [PTR_W-1:0]  w_slot;

    assign o_full      = r_count == (PTR_W+1)'(DEPTH);
    assign o_empty     = r_count == '0;
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];

    // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap on their own.
    // A push and a pop never target the same slot: that would need the buffer
    // to be both empty (no pop) and full (no push).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_valid[r_tail] <= 1'b1;
            if (i_pop) r_valid[r_head] <= 1'b0;
            r_head  <= r_head + PTR_W'(i_pop);
            r_tail  <= r_tail + PTR_W'(i_push);
            r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
        end
    end

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_slot     = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = r_head + PTR_W'(k);
            if (r_valid[w_slot] && r_addr[w_slot] == i_srch_addr) begin
                o_hit      = 1'b1;
                o_hit_data = r_data[w_slot];
            end
        end
    end

endmodule

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: CPU data-memory stage with an in-order write buffer draining to a single-port RAM
//
// Build option: define DMEM_WBUF_FWD_EN to forward load hits from the write buffer;
// without it a load that matches a buffered store stalls until that store has drained.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_dm_ena/_w/_r            request valid, store, load (store wins when both are set)
//   i_dm_addr                 CPU byte address; only the word index is used
//   i_dm_wdata                store data
//   o_dm_rdata                load data, combinational
//   o_stall                   CPU must hold its PC and request this cycle
//   o_ram_addr/_we/_wdata     single RAM port: load-miss read or buffer drain write
//   i_ram_rdata               RAM combinational read data
module dmem_wbuf
    import dmem_pkg::word_index;
#(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W,
    parameter int DEPTH  = dmem_pkg::DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_dm_ena,
    input  logic              i_dm_w,
    input  logic              i_dm_r,
    input  logic [31:0]       i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_stall,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    logic [ADDR_W-1:0] w_idx;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [DATA_W-1:0] w_hit_data;
    logic              w_store;
    logic              w_load;
    logic              w_full;
    logic              w_empty;
    logic              w_hit;
    logic              w_miss;
    logic              w_push;
    logic              w_pop;

    assign w_idx = ADDR_W'(word_index(i_dm_addr));

    // Requests are masked while reset is held so every output reads zero.
    assign w_store = i_rst_n & i_dm_ena & i_dm_w;
    assign w_load  = i_rst_n & i_dm_ena & i_dm_r & ~i_dm_w;
    assign w_miss  = w_load & ~w_hit;
    assign w_push  = w_store & ~w_full;
    // A load miss owns the RAM port; otherwise the oldest store drains.
    assign w_pop   = ~w_empty & ~w_miss;

`ifdef DMEM_WBUF_FWD_EN
    assign o_stall = w_store & w_full;
`else
    // Without forwarding a matching load waits for its store to reach the RAM.
    assign o_stall = (w_store & w_full) | (w_load & w_hit);
`endif

    // While a hit-load is stalled the CPU ignores o_dm_rdata, so one mux serves both builds.
    assign o_dm_rdata  = w_load ? (w_hit ? w_hit_data : i_ram_rdata) : '0;
    assign o_ram_we    = w_pop;
    assign o_ram_addr  = w_miss ? w_idx : (w_pop ? w_head_addr : '0);
    assign o_ram_wdata = w_pop ? w_head_data : '0;

    dmem_wbuf_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_addr (w_idx),
        .i_push_data (i_dm_wdata),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .i_srch_addr (w_idx),
        .o_hit       (w_hit),
        .o_hit_data  (w_hit_data)
    );

endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: scoreboard bench for dmem_wbuf against a queue-based reference model
module tb_dmem_wbuf;
    import dmem_pkg::*;

    localparam int AW = ADDR_W;
    localparam int DW = DATA_W;
    localparam int DP = DEPTH;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          miss;
        logic [AW-1:0] a;
    } rd_t;

    typedef struct packed {
        logic stall;
        logic rst;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          w = 1'b0;
    logic          r = 1'b0;
    logic [31:0]   addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          stall;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] ram_w [0:(1<<AW)-1];
    bit            ram_v [0:(1<<AW)-1];

    wbuf_entry_t   buf_q [$];
    wbuf_entry_t   wr_q [$];
    rd_t           rd_q [$];
    cyc_t          cyc_q [$];
    logic [DW-1:0] mdl [int];

    int  checks = 0;
    int  errors = 0;
    bit  running = 1'b0;
    bit  st;

    always #5 clk = ~clk;

    dmem_wbuf dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_dm_ena    (ena),
        .i_dm_w      (w),
        .i_dm_r      (r),
        .i_dm_addr   (addr),
        .i_dm_wdata  (wdata),
        .o_dm_rdata  (rdata),
        .o_stall     (stall),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return DW'(32'hC0DE_0000 ^ (32'(a) * 32'h0001_0203));
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mdl.exists(int'(a)) ? mdl[int'(a)] : init_word(a);
    endfunction

    assign ram_rdata = ram_v[ram_addr] ? ram_w[ram_addr] : init_word(ram_addr);

    always @(posedge clk) begin
        if (ram_we) begin
            ram_w[ram_addr] <= ram_wdata;
            ram_v[ram_addr] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // One CPU cycle: drive the request and predict the cycle from the buffer-as-a-queue model.
    task automatic step(input bit e, input bit we_, input bit re, input logic [31:0] a,
                        input logic [DW-1:0] d, output bit stl);
        logic [AW-1:0] idx;
        logic [DW-1:0] hd;
        bit            ld, hit, miss, full;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena   = e;
        w     = we_;
        r     = re;
        addr  = a;
        wdata = d;
        idx   = AW'(a >> 2);
        ld    = e & re & ~we_;
        full  = buf_q.size() == DP;
        hit   = 1'b0;
        hd    = '0;
        foreach (buf_q[i]) begin
            if (buf_q[i].addr == idx) begin
                hit = 1'b1;
                hd  = buf_q[i].data;
            end
        end
        miss = ld & ~hit;
`ifdef DMEM_WBUF_FWD_EN
        stl = e & we_ & full;
        if (ld) rd_q.push_back('{hit ? hd : mem_rd(idx), miss, idx});
`else
        stl = (e & we_ & full) | (ld & hit);
        if (miss) rd_q.push_back('{mem_rd(idx), 1'b1, idx});
`endif
        cyc_q.push_back('{stl, 1'b0});
        if (buf_q.size() > 0 && !miss) begin
            wr_q.push_back(buf_q[0]);
            mdl[int'(buf_q[0].addr)] = buf_q[0].data;
            buf_q.delete(0);
        end
        if (e && we_ && !stl) buf_q.push_back('{1'b1, idx, d});
    endtask

    // Issue a request and hold it while the model says the CPU is stalled.
    task automatic req(input bit e, input bit we_, input bit re, input logic [31:0] a,
                       input logic [DW-1:0] d);
        bit s;
        int n = 0;
        step(e, we_, re, a, d, s);
        while (s && n < 16) begin
            step(e, we_, re, a, d, s);
            n++;
        end
        if (s) begin
            checks++;
            errors++;
            $display("FAIL stall_bound: got stalled, want released within 16 cycles");
        end
    endtask

    task automatic rst_cycle(input logic [31:0] a);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ena   = 1'b1;
        w     = 1'b0;
        r     = 1'b1;
        addr  = a;
        wdata = '1;
        buf_q.delete();
        cyc_q.push_back('{1'b0, 1'b1});
    endtask

    always @(negedge clk) begin : mon
        cyc_t        c;
        wbuf_entry_t e;
        rd_t         d;
        if (running) begin
            if (cyc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cyc_q: got empty queue, want a cycle expectation");
            end else begin
                c = cyc_q.pop_front();
                chk("stall", 64'(stall), 64'(c.stall));
                if (c.rst) begin
                    chk("rst_ram_we", 64'(ram_we), 64'(0));
                    chk("rst_dm_rdata", 64'(rdata), 64'(0));
                    chk("rst_ram_addr", 64'(ram_addr), 64'(0));
                    chk("rst_ram_wdata", 64'(ram_wdata), 64'(0));
                end else begin
                    if (ram_we) begin
                        if (wr_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: got addr %0h data %0h, want no write", ram_addr, ram_wdata);
                        end else begin
                            e = wr_q.pop_front();
                            chk("wr_addr", 64'(ram_addr), 64'(e.addr));
                            chk("wr_data", 64'(ram_wdata), 64'(e.data));
                        end
                    end
                    if (ena && r && !w) begin
                        if (!stall) begin
                            if (rd_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_load: got data %0h, want no serviced load", rdata);
                            end else begin
                                d = rd_q.pop_front();
                                chk("dm_rdata", 64'(rdata), 64'(d.d));
                                if (d.miss) begin
                                    chk("miss_ram_addr", 64'(ram_addr), 64'(d.a));
                                    chk("miss_ram_we", 64'(ram_we), 64'(0));
                                end
                            end
                        end
                    end else begin
                        chk("idle_dm_rdata", 64'(rdata), 64'(0));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          k;
        running = 1'b1;
        rst_cycle(32'h0000_0010);
        rst_cycle(32'h0000_0020);
        // store then load of the same word, different byte offset
        req(1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF);
        req(1, 0, 1, 32'h0000_0013, '0);
        // youngest match with load misses blocking the drain
        req(1, 1, 0, 32'h0000_0040, 32'h1);
        req(1, 0, 1, 32'h0000_0800, '0);
        req(1, 1, 0, 32'h0000_0040, 32'h2);
        req(1, 0, 1, 32'h0000_0804, '0);
        req(1, 0, 1, 32'h0000_0040, '0);
        // stores interleaved with load misses, then a fifth store
        for (int i = 0; i < 4; i++) begin
            req(1, 1, 0, 32'h0000_0600 + 32'(i * 4), 32'hA000 + DW'(i));
            req(1, 0, 1, 32'h0000_0700 + 32'(i * 4), '0);
        end
        req(1, 1, 0, 32'h0000_0610, 32'hA004);
        // sequential stores wrap the pointers
        for (int i = 0; i < 10; i++) req(1, 1, 0, 32'h0000_0100 + 32'(i * 4), 32'hB000 + DW'(i));
        // port priority: load miss while the buffer holds a store
        req(1, 1, 0, 32'h0000_0300, 32'hC0FF_EE00);
        req(1, 0, 1, 32'h0000_0200, '0);
        req(0, 0, 0, '0, '0);
        // both request bits high behaves as a store
        req(1, 1, 1, 32'h0000_0044, 32'h5555_AAAA);
        req(1, 0, 1, 32'h0000_0044, '0);
        // reset with a store still buffered; the store must never reach the RAM
        req(1, 1, 0, 32'h0000_0500, 32'hBAD0_0001);
        req(1, 0, 1, 32'h0000_0900, '0);
        rst_cycle(32'h0000_0500);
        rst_cycle(32'h0000_0500);
        req(0, 0, 0, '0, '0);
        req(1, 0, 1, 32'h0000_0500, '0);
        // randomized traffic over a small set of word indices, with junk in ignored bits
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 9));
            a = ($urandom & ~32'h0000_1FFC) | (32'($urandom_range(0, 7)) << 2);
            if (k == 0) req(0, 1'($urandom), 1'($urandom), a, $urandom);
            else if (k == 1) req(1, 1, 1, a, $urandom);
            else if (k < 6) req(1, 1, 0, a, $urandom);
            else req(1, 0, 1, a, '0);
        end
        for (int i = 0; i < 4; i++) req(0, 0, 0, '0, '0);
        @(posedge clk);
        running = 1'b0;
        chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
        chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
        chk("cyc_q_drained", 64'(cyc_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
